// File: rtl/video_pkg.sv
// Shared video-path types and constants: capture FSM states, RGB565 field
// layout and the coordinate width used by the DVP capture block.
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_WAIT_VS = 2'd2,
    ST_ACTIVE  = 2'd3
  } cap_state_t;

  localparam int COORD_W = 12;

  localparam int RGB_R_LSB = 11;
  localparam int RGB_R_W   = 5;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_G_W   = 6;
  localparam int RGB_B_LSB = 0;
  localparam int RGB_B_W   = 5;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  function automatic logic [COORD_W-1:0] coord_sat_inc(
    input logic [COORD_W-1:0] v,
    input logic [COORD_W-1:0] lim
  );
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/dvp_sync_edge.sv
// Registers DVP vsync/href once on the pixel clock and derives one-cycle
// rise/fall strobes from the registered copies.
module dvp_sync_edge #(
  parameter bit VS_POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vsync,
  input  logic i_href,
  output logic o_vs_r,
  output logic o_href_r,
  output logic o_vs_rise,
  output logic o_vs_fall,
  output logic o_href_rise,
  output logic o_href_fall
);

  logic r_vs, r_vs_q, r_href, r_href_q;

  // vsync resets to its active-video level so a sensor already mid-frame
  // does not look like blanking right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs     <= ~VS_POL;
      r_vs_q   <= ~VS_POL;
      r_href   <= 1'b0;
      r_href_q <= 1'b0;
    end else begin
      r_vs     <= i_vsync;
      r_vs_q   <= r_vs;
      r_href   <= i_href;
      r_href_q <= r_href;
    end
  end

  assign o_vs_r      = r_vs;
  assign o_href_r    = r_href;
  assign o_vs_rise   = r_vs & ~r_vs_q;
  assign o_vs_fall   = ~r_vs & r_vs_q;
  assign o_href_rise = r_href & ~r_href_q;
  assign o_href_fall = ~r_href & r_href_q;

endmodule

// File: rtl/dvp_rgb565_capture.sv
// OV5640 DVP capture: pairs bytes into RGB565 beats with x/y coordinates and
// frame markers. Define DVP_LINE_CHECK_EN to build the sticky line-length checker.
module dvp_rgb565_capture
  import video_pkg::*;
#(
  parameter int H_ACTIVE    = 480,
  parameter int V_ACTIVE    = 272,
  parameter int SKIP_FRAMES = 10,
  parameter bit VS_POL      = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cam_vsync,
  input  logic                cam_href,
  input  logic [7:0]          cam_data,
  output logic [15:0]         o_data,
  output logic                o_valid,
  output logic [COORD_W-1:0]  o_x,
  output logic [COORD_W-1:0]  o_y,
  output logic                o_sof,
  output logic                o_eof,
  output logic [7:0]          o_frame_cnt,
  output logic                o_err
);

  localparam logic [COORD_W-1:0] H_LIM     = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM     = COORD_W'(V_ACTIVE);
  localparam logic [7:0]         SKIP_INIT = 8'(SKIP_FRAMES);

  logic w_vs_r, w_href_r, w_vs_rise, w_vs_fall, w_href_rise, w_href_fall;
  logic w_vs_enter, w_vs_exit, w_blank;

  dvp_sync_edge #(.VS_POL(VS_POL)) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_vsync     (cam_vsync),
    .i_href      (cam_href),
    .o_vs_r      (w_vs_r),
    .o_href_r    (w_href_r),
    .o_vs_rise   (w_vs_rise),
    .o_vs_fall   (w_vs_fall),
    .o_href_rise (w_href_rise),
    .o_href_fall (w_href_fall)
  );

  assign w_blank    = (w_vs_r == VS_POL);
  assign w_vs_enter = VS_POL ? w_vs_rise : w_vs_fall;
  assign w_vs_exit  = VS_POL ? w_vs_fall : w_vs_rise;

  logic [7:0] r_d_p0;
  logic [7:0] r_hi_p1;

  always_ff @(posedge clk) begin
    r_d_p0 <= cam_data;
  end

  cap_state_t r_state, w_state_nxt;
  logic [7:0] r_skip_cnt;
  logic       w_frame_start, w_frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_blank) w_state_nxt = (SKIP_INIT == 8'd0) ? ST_WAIT_VS : ST_SKIP;
      end
      ST_SKIP: begin
        if (r_skip_cnt == 8'd0 && w_blank) w_state_nxt = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (w_vs_exit) begin
          w_state_nxt   = ST_ACTIVE;
          w_frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_vs_enter) begin
          w_state_nxt = ST_WAIT_VS;
          w_frame_end = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One count per settling frame, taken as the sensor leaves blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip_cnt <= 8'd0;
    end else if (r_state == ST_IDLE && w_blank) begin
      r_skip_cnt <= SKIP_INIT;
    end else if (r_state == ST_SKIP && w_vs_exit && r_skip_cnt != 8'd0) begin
      r_skip_cnt <= r_skip_cnt - 8'd1;
    end
  end

  logic                r_phase, r_line_pix, r_sof_arm;
  logic [COORD_W-1:0]  r_x, r_y;
  logic [7:0]          r_frame_cnt;
  logic                w_capture, w_phase_eff, w_pix_done, w_in_win, w_beat;

  // A frame-end edge wins over capture, so a pixel completing on that cycle is dropped.
  assign w_capture   = (r_state == ST_ACTIVE) && !w_vs_enter;
  assign w_phase_eff = r_phase & ~w_href_rise;
  assign w_pix_done  = w_capture && w_href_r && w_phase_eff;
  assign w_in_win    = (r_x < H_LIM) && (r_y < V_LIM);
  assign w_beat      = w_pix_done && w_in_win;

  always_ff @(posedge clk) begin
    if (w_capture && w_href_r && !w_phase_eff) r_hi_p1 <= r_d_p0;
  end

  // Output stage: data, coordinates and strobes leave together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= 1'b0;
      r_line_pix  <= 1'b0;
      r_sof_arm   <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_frame_cnt <= 8'd0;
      o_data      <= 16'd0;
      o_valid     <= 1'b0;
      o_x         <= '0;
      o_y         <= '0;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
      if (w_frame_start) begin
        r_x        <= '0;
        r_y        <= '0;
        r_phase    <= 1'b0;
        r_line_pix <= 1'b0;
        r_sof_arm  <= 1'b1;
      end else if (w_frame_end) begin
        r_phase     <= 1'b0;
        r_line_pix  <= 1'b0;
        r_frame_cnt <= r_frame_cnt + 8'd1;
        o_eof       <= 1'b1;
      end else if (w_capture) begin
        if (w_href_r) begin
          r_phase <= ~w_phase_eff;
          if (w_pix_done) begin
            r_x        <= coord_sat_inc(r_x, COORD_MAX);
            r_line_pix <= 1'b1;
            r_sof_arm  <= 1'b0;
            if (w_beat) begin
              o_valid <= 1'b1;
              o_data  <= {r_hi_p1, r_d_p0};
              o_x     <= r_x;
              o_y     <= r_y;
              o_sof   <= r_sof_arm;
            end
          end
        end else if (w_href_fall) begin
          r_phase    <= 1'b0;
          r_x        <= '0;
          r_line_pix <= 1'b0;
          if (r_line_pix) r_y <= coord_sat_inc(r_y, V_LIM);
        end
      end
    end
  end

  assign o_frame_cnt = r_frame_cnt;

`ifdef DVP_LINE_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_capture && w_href_fall && r_y < V_LIM && r_x != H_LIM) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Bench for dvp_rgb565_capture on a reduced 8x4 raster with two settling
// frames; beats are matched against a scoreboard of expected pixels.
module tb_dvp_rgb565_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int SK = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic [15:0] o_data;
  logic        o_valid;
  logic [11:0] o_x, o_y;
  logic        o_sof, o_eof;
  logic [7:0]  o_frame_cnt;
  logic        o_err;

  dvp_rgb565_capture #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .SKIP_FRAMES (SK),
    .VS_POL      (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_x         (o_x),
    .o_y         (o_y),
    .o_sof       (o_sof),
    .o_eof       (o_eof),
    .o_frame_cnt (o_frame_cnt),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
    logic        sof;
    int          cyc;
  } exp_t;

  vec_t tbl[8];
  exp_t q[$];
  exp_t mon_e;

  int total = 0, bad = 0;
  int cyc = 0;
  int eof_seen = 0, sof_seen = 0;
  int exp_eof = 0;
  int exp_fcnt = 0;
  bit exp_err = 1'b0;
  bit cap = 1'b0;
  bit sof_arm = 1'b0;
  int mx = 0, my = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_eof) eof_seen++;
      if (o_sof) begin
        sof_seen++;
        check("sof_with_valid", {31'd0, o_valid}, 32'd1);
      end
      if (o_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: actual beat %h at (%0d,%0d), required none", o_data, o_x, o_y);
        end else begin
          mon_e = q.pop_front();
          check("beat_data", {16'd0, o_data}, {16'd0, mon_e.d});
          check("beat_x", {20'd0, o_x}, mon_e.x);
          check("beat_y", {20'd0, o_y}, mon_e.y);
          check("beat_sof", {31'd0, o_sof}, {31'd0, mon_e.sof});
          check("beat_latency_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] d, input logic h);
    @(negedge clk);
    cam_data = d;
    cam_href = h;
  endtask

  task automatic line(input int nbytes, input bit tbl_mode, input bit hold);
    logic [7:0]  hi, lo;
    logic [15:0] ex;
    exp_t        e;
    int          p;
    hi = 8'h00;
    for (int b = 0; b < nbytes; b++) begin
      p = b / 2;
      if (b % 2 == 0) begin
        hi = tbl_mode ? tbl[p % 8].hi : 8'($urandom);
        drive(hi, 1'b1);
      end else begin
        lo = tbl_mode ? tbl[p % 8].lo : 8'($urandom);
        drive(lo, 1'b1);
        ex = tbl_mode ? tbl[p % 8].exp : {hi, lo};
        if (cap) begin
          if (mx < H && my < V) begin
            e.d = ex; e.x = mx; e.y = my; e.sof = sof_arm; e.cyc = cyc + 2;
            q.push_back(e);
          end
          sof_arm = 1'b0;
          mx++;
        end
      end
    end
    if (!hold) begin
      drive(8'h00, 1'b0);
      if (cap) begin
`ifdef DVP_LINE_CHECK_EN
        if (my < V && mx != H) exp_err = 1'b1;
`endif
        if (mx > 0) my = (my < V) ? my + 1 : V;
      end
      mx = 0;
      repeat (2) drive(8'h00, 1'b0);
    end
  endtask

  task automatic frame_boundary(input bit next_cap);
    @(negedge clk);
    cam_href  = 1'b0;
    cam_vsync = 1'b1;
    repeat (3) @(negedge clk);
    if (cap) begin
      exp_eof++;
      exp_fcnt = (exp_fcnt + 1) % 256;
    end
    @(negedge clk);
    cam_vsync = 1'b0;
    cap = next_cap;
    sof_arm = next_cap;
    mx = 0;
    my = 0;
    repeat (3) drive(8'h00, 1'b0);
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) line(2 * H, 1'b0, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  {16'd0, o_data}, 32'd0);
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    check({tag, "_x"},     {20'd0, o_x}, 32'd0);
    check({tag, "_y"},     {20'd0, o_y}, 32'd0);
    check({tag, "_sof"},   {31'd0, o_sof}, 32'd0);
    check({tag, "_eof"},   {31'd0, o_eof}, 32'd0);
    check({tag, "_fcnt"},  {24'd0, o_frame_cnt}, 32'd0);
    check({tag, "_err"},   {31'd0, o_err}, 32'd0);
  endtask

  task automatic check_frame_stats(input string tag, input int sofs);
    repeat (4) @(negedge clk);
    #1;
    check({tag, "_eof_count"}, eof_seen, exp_eof);
    check({tag, "_frame_cnt"}, {24'd0, o_frame_cnt}, exp_fcnt);
    check({tag, "_sof_count"}, sof_seen, sofs);
    check({tag, "_err"}, {31'd0, o_err}, {31'd0, exp_err});
    check({tag, "_queue_drained"}, q.size(), 0);
  endtask

  initial begin
    tbl[0] = '{8'hF8, 8'h00, 16'hF800};
    tbl[1] = '{8'h07, 8'hE0, 16'h07E0};
    tbl[2] = '{8'h00, 8'h1F, 16'h001F};
    tbl[3] = '{8'hFF, 8'hFF, 16'hFFFF};
    tbl[4] = '{8'h12, 8'h34, 16'h1234};
    tbl[5] = '{8'hA5, 8'h5A, 16'hA55A};
    tbl[6] = '{8'h00, 8'h00, 16'h0000};
    tbl[7] = '{8'h80, 8'h01, 16'h8001};

    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) drive(8'h00, 1'b0);

    // Two settling frames, then frames 3 and 4 captured.
    frame_boundary(1'b0); lines(V);
    frame_boundary(1'b0); lines(V);
    frame_boundary(1'b1); line(2 * H, 1'b1, 1'b0); lines(V - 1);
    frame_boundary(1'b1); lines(V);
    frame_boundary(1'b1);
    check_frame_stats("after_f4", 2);
    check("frame_cnt_two_after_f4", {24'd0, o_frame_cnt}, 32'd2);

    // Odd byte count, clean table line, over-long line, too many lines.
    line(2 * H + 1, 1'b0, 1'b0);
    line(2 * H, 1'b1, 1'b0);
    #1 check("err_after_odd_line", {31'd0, o_err}, {31'd0, exp_err});
    line(2 * (H + 4), 1'b0, 1'b0);
    #1 check("err_after_long_line", {31'd0, o_err}, {31'd0, exp_err});
    lines(4);
    frame_boundary(1'b1);
    check_frame_stats("after_f5", 3);

    // Frame aborted by vsync while href is high, mid-pixel.
    line(2 * H, 1'b1, 1'b0);
    drive(8'h5A, 1'b1);
    @(negedge clk);
    cam_vsync = 1'b1;
    cam_data  = 8'hA5;
    cam_href  = 1'b1;
    drive(8'h00, 1'b0);
    repeat (3) drive(8'h00, 1'b0);
    exp_eof++;
    exp_fcnt = (exp_fcnt + 1) % 256;
    @(negedge clk);
    cam_vsync = 1'b0;
    cap = 1'b1; sof_arm = 1'b1; mx = 0; my = 0;
    repeat (3) drive(8'h00, 1'b0);
    check_frame_stats("after_abort", 4);

    // Reset asserted right after the beat at pixel (3,2).
    line(2 * H, 1'b1, 1'b0);
    line(2 * H, 1'b1, 1'b0);
    line(8, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midframe_reset");
    q.delete();
    cam_href = 1'b0;
    cap = 1'b0; sof_arm = 1'b0; mx = 0; my = 0;
    exp_err = 1'b0; exp_eof = 0; exp_fcnt = 0;
    eof_seen = 0; sof_seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_outputs_zero("after_release");

    // Remainder of the interrupted frame, two full settling frames, one captured.
    line(2 * H, 1'b0, 1'b0);
    frame_boundary(1'b0); lines(V);
    frame_boundary(1'b0); lines(V);
    frame_boundary(1'b1); line(2 * H, 1'b1, 1'b0); lines(V - 1);
    frame_boundary(1'b1);
    check_frame_stats("after_reset_resume", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dvp_rgb565_capture.md
# dvp_rgb565_capture

Camera-side capture block for the OV5640 → SDRAM → LCD video path. It samples the OV5640 8-bit DVP bus and pairs consecutive bytes into RGB565 pixels. It generates pixel/line coordinates and frame markers, and presents one 16-bit write beat per pixel to the SDRAM write FIFO. It is the producer of the RGB565 words that the display-side processing later reads back from SDRAM.

## Interface
- H_ACTIVE, 480: expected pixels per line (AN430 panel width).
- V_ACTIVE, 272: expected lines per frame.
- SKIP_FRAMES, 10: full frames discarded after reset while the sensor settles; range 0..255.
- VS_POL, 1: level of cam_vsync during vertical blanking.
- clk  in  1  DVP pixel clock (cam_pclk).
- rst_n  in  1  asynchronous, active-low reset.
- cam_vsync  in  1  DVP vertical sync.
- cam_href  in  1  DVP line valid, active high.
- cam_data  in  8  DVP byte.
- o_data  out  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
- o_valid  out  1  o_data/o_x/o_y valid this cycle (FIFO write enable).
- o_x  out  12  pixel column, 0..H_ACTIVE-1.
- o_y  out  12  line row, 0..V_ACTIVE-1.
- o_sof  out  1  one-cycle pulse coincident with the beat at (0,0).
- o_eof  out  1  one-cycle pulse at the end of each captured frame (vsync entering blanking).
- o_frame_cnt  out  8  captured frames since reset, wraps 255→0.
- o_err  out  1  sticky line-length error (present only with DVP_LINE_CHECK_EN, else tied 0).

## Operation
- Input stage: cam_vsync, cam_href, and cam_data are registered once on clk; all logic uses the registered copies (vs_r, href_r, d_r).
- FSM states: IDLE → SKIP → WAIT_VS → ACTIVE.
  - IDLE: wait for vs_r == VS_POL. When it is seen, load skip_cnt = SKIP_FRAMES and go to SKIP.
  - SKIP: each blanking→active vsync transition decrements skip_cnt. Go to WAIT_VS when skip_cnt reaches 0 and vs_r == VS_POL. With SKIP_FRAMES = 0, go to WAIT_VS directly.
  - WAIT_VS: at the vs_r transition out of blanking, clear x, y, and byte phase, arm the sof flag, and go to ACTIVE.
  - ACTIVE: capture pixels. At the vs_r transition into blanking, pulse o_eof, increment o_frame_cnt, and go to WAIT_VS.
- Byte pairing, ACTIVE with href_r = 1:
  - Phase 0 latches d_r as the high byte [15:8].
  - Phase 1 forms {hi, d_r} and issues a beat.
  - Phase toggles every href_r cycle.
- Falling href_r:
  - Clear phase and discard any dangling high byte.
  - Set x = 0.
  - If the line produced ≥1 beat, set y = y+1, saturating at V_ACTIVE.
- Beats are suppressed (o_valid = 0) when x ≥ H_ACTIVE or y ≥ V_ACTIVE. x keeps counting to 4095 and saturates.
- vs_r entering blanking while href_r = 1 aborts the line: no beat for a partial pixel, and o_eof is pulsed as normal.
- Reset while mid-frame: all state is cleared to IDLE and the skip count restarts in full.

## Timing
- Reset values: o_data = 0, o_valid = 0, o_x = 0, o_y = 0, o_sof = 0, o_eof = 0, o_frame_cnt = 0, o_err = 0.
- Latency: o_valid is asserted on the 2nd clk edge after the second byte of a pixel is on cam_data (1 input register + 1 output register).
- o_data, o_x, o_y, and o_valid are registered together. o_x/o_y hold the coordinate of the beat they accompany.
- Throughput: at most one beat per 2 clk cycles. There is no backpressure, so the downstream FIFO must accept every beat.
- o_sof is high only with the first beat of a frame. If that beat is suppressed, o_sof is not issued for that frame.
- o_eof is registered one cycle after the detected vs_r edge.

## Configuration
- DVP_LINE_CHECK_EN, when defined:
  - At each falling href_r in ACTIVE with y < V_ACTIVE, if the pixel count ≠ H_ACTIVE, set o_err.
  - o_err clears only on reset.
- When undefined: no checker logic is built and o_err is constant 0.

## Structure
- Shared package `video_pkg`:
  - state enum (IDLE, SKIP, WAIT_VS, ACTIVE).
  - RGB565 field offsets.
  - 12-bit coordinate width constant.
- One natural sub-module: `dvp_sync_edge`, which registers vsync/href and outputs vs_r, href_r, and the rise/fall strobes for each.

## Test plan
- SKIP_FRAMES = 2, reset, then 4 frames → first o_sof on frame 3, o_frame_cnt = 2 after frame 4 ends.
- Line with bytes 0xF8,0x00,0x07,0xE0 → beats 0xF800 at x = 0 and 0x07E0 at x = 1, each valid 2 edges after its second byte.
- href drops after 961 bytes → 480 beats, odd byte discarded, next line starts at x = 0 and phase 0. With DVP_LINE_CHECK_EN, o_err stays 0.
- Line of 484 pixels → beats only for x = 0..479. With DVP_LINE_CHECK_EN, o_err = 1 and remains set.
- 275 lines in a frame → beats only for y = 0..271; o_eof is pulsed once at vsync.
- rst_n asserted at pixel (100,50) → all outputs 0 immediately. After release, capture resumes only after SKIP_FRAMES full frames.
